// File: rtl/uart_rx_word.sv
// -----------------------------------------------------------------------------
// uart_rx_word
//
// 8N1 UART receiver. It recovers bytes from the serial line `rx` and packs each
// group of four accepted bytes into one 32-bit word. The first byte received
// lands in [31:24] and the fourth in [7:0].
//
// Ports
//   clk         in   1   system clock
//   rst_n       in   1   synchronous, active-low reset
//   rx          in   1   asynchronous serial input, idles high
//   data_out    out  32  last completed word, held until the next one
//   data_valid  out  1   one-cycle strobe, data_out is new in this cycle
//   frame_err   out  1   one-cycle strobe, a stop bit was sampled low
//   busy        out  1   receiver FSM is outside IDLE
//
// Parameters
//   CLK_FREQ, BAUD  give CLKS_PER_BIT = CLK_FREQ/BAUD clocks per bit
//   TIMEOUT_BITS    inter-byte idle limit in bit periods
//
// Build option
//   UART_RX_TIMEOUT_EN  When defined, a partial word is dropped after the line
//                       has been idle for TIMEOUT_BITS bit periods between
//                       bytes. When undefined, a partial word is kept until more
//                       bytes arrive or reset is applied.
// -----------------------------------------------------------------------------
module uart_rx_word #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  // A bit period of fewer than 4 clocks leaves no usable mid-bit point.
  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_cfg_error
    $error("uart_rx_word: CLK_FREQ/BAUD must be >= 4 and TIMEOUT_BITS >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]         byte_sr_q, byte_sr_d;
  logic [31:0]        word_sr_q, word_sr_d;
  logic [31:0]        data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               rx_meta_q, rx_s_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both flops reset high so that reset never looks like
  // a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    byte_cnt_d   = byte_cnt_q;
    byte_sr_d    = byte_sr_q;
    word_sr_d    = word_sr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is already high again at mid start bit was a glitch.
          state_d   = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          byte_sr_d = {rx_s_q, byte_sr_q[7:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Return to IDLE at mid stop bit so that a start edge right after
            // one stop bit is still caught.
            state_d    = ST_IDLE;
            word_sr_d  = {word_sr_q[23:0], byte_sr_q};
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              data_out_d   = {word_sr_q[23:0], byte_sr_q};
              data_valid_d = 1'b1;
            end
          end else begin
            state_d     = ST_WAIT;
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef UART_RX_TIMEOUT_EN
  // The timeout counter runs only while a partial word waits in IDLE. A start
  // edge, or any state other than IDLE, clears it.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_IDLE && rx_s_q && byte_cnt_q != 2'd0) begin
      if (to_cnt_q == TO_W'(TO_LIMIT)) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      byte_cnt_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      // The stale bytes left in word_sr_q are shifted out by the next four
      // accepted bytes, so clearing the count alone discards the partial word.
      if (state_q == ST_IDLE && rx_s_q && byte_cnt_q != 2'd0 &&
          to_cnt_q == TO_W'(TO_LIMIT)) begin
        byte_cnt_q <= '0;
      end else begin
        byte_cnt_q <= byte_cnt_d;
      end
`else
      byte_cnt_q   <= byte_cnt_d;
`endif
    end
  end

  // Byte and word shift registers. These have no reset because byte_cnt_q
  // decides which of their contents are meaningful.
  always_ff @(posedge clk) begin
    byte_sr_q <= byte_sr_d;
    word_sr_q <= word_sr_d;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
module tb_uart_rx_word;

  localparam int CLK_FREQ     = 3_200_000;
  localparam int BAUD         = 100_000;
  localparam int TIMEOUT_BITS = 20;
  localparam int CPB          = CLK_FREQ / BAUD;   // 32 clocks per bit

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_word #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: bytes of the word being assembled, completed words
  // the DUT still owes, and outstanding framing-error pulses.
  logic [7:0]  part_q[$];
  logic [31:0] exp_q[$];
  int          ferr_pend = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- Monitor / scoreboard ----------------
  logic [31:0] last_word = '0;
  logic        prev_valid = 1'b0;
  int          last_valid_cyc = 0;
  int          valid_gap = 0;
  int          valid_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_word  = '0;
      prev_valid = 1'b0;
    end else begin
      if (data_valid) begin
        valid_seen++;
        check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got data_out=0x%08h expected no pulse", data_out);
        end else begin
          last_word = exp_q.pop_front();
          check("data_out", data_out, last_word);
        end
        valid_gap      = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
      end else begin
        check("data_out_hold", data_out, last_word);
      end
      if (frame_err) begin
        checks++;
        if (ferr_pend == 0) begin
          failures++;
          $display("FAIL unexpected_frame_err: got pulse expected none");
        end else begin
          ferr_pend--;
        end
      end
      prev_valid = data_valid;
    end
  end

  // ---------------- Reference model ----------------
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        exp_q.push_back({part_q[0], part_q[1], part_q[2], part_q[3]});
        part_q.delete();
      end
    end else begin
      ferr_pend++;
      part_q.delete();
    end
  endtask

  // ---------------- Driver ----------------
  task automatic bit_time();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
`ifdef UART_RX_TIMEOUT_EN
    if (n >= TIMEOUT_BITS) part_q.delete();
`endif
    repeat (n) bit_time();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
    // Expectation is queued before the stop bit, since the DUT reports mid-bit.
    model_byte(b, stop_ok);
    rx = stop_ok;
    bit_time();
    rx = 1'b1;
    if (!stop_ok) bit_time();
    idle_bits(gap_bits);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_bits);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1, gap_bits);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    part_q.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    int v0;
    bit seen;
    bit fell;
    logic [7:0] rb;

    do_reset();

    // Back-to-back 0xAA 0x55 0xAA 0x55
    v0 = valid_seen;
    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'h55, 1'b1, 2);
    check("aa55_pulse_count", valid_seen - v0, 32'd1);
    check("aa55_value", data_out, 32'hAA55AA55);

    // Short low glitch on rx
    v0 = valid_seen;
    seen = 1'b0;
    fell = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) begin
        fell = 1'b1;
        break;
      end
    end
    check("glitch_busy_seen", {31'd0, seen}, 32'd1);
    check("glitch_busy_fall", {31'd0, fell}, 32'd1);
    idle_bits(2);
    check("glitch_no_valid", valid_seen - v0, 32'd0);

    // Framing error, then a clean word
    v0 = valid_seen;
    send_byte(8'h12, 1'b1, 1);
    send_byte(8'h31, 1'b0, 2);
    check("ferr_no_valid", valid_seen - v0, 32'd0);
    check("ferr_consumed", ferr_pend, 32'd0);
    send_word(32'h12312312, 0);
    idle_bits(2);
    check("after_ferr_value", data_out, 32'h12312312);

    // Two contiguous words; pulses should be 40 bit periods apart
    send_word(32'h01020304, 0);
    send_word(32'hDEADBEEF, 0);
    idle_bits(2);
    check("two_words_last", data_out, 32'hDEADBEEF);
    checks++;
    if (valid_gap < 40*CPB - 3 || valid_gap > 40*CPB + 3) begin
      failures++;
      $display("FAIL word_spacing: got %0d cycles expected %0d +/-3", valid_gap, 40*CPB);
    end

    // Reset in the middle of the third byte of a word
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    rb = 8'h33;
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 3; i++) begin
      rx = rb[i];
      bit_time();
    end
    do_reset();
    send_word(32'hCAFEF00D, 1);
    idle_bits(1);
    check("post_reset_word", data_out, 32'hCAFEF00D);

    // Randomised bytes, gaps and framing errors
    for (int i = 0; i < 16; i++) begin
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), $urandom_range(0, 3));
    end
    idle_bits(2);

    // Inter-byte timeout (behaviour depends on the build option)
    do_reset();
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 25);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 0);
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h66, 1'b1, 2);
`ifdef UART_RX_TIMEOUT_EN
    check("timeout_word", data_out, 32'h33445566);
`else
    check("no_timeout_word", data_out, 32'h11223344);
`endif

    idle_bits(3);
    check("exp_queue_empty", exp_q.size(), 32'd0);
    check("ferr_pending", ferr_pend, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(80000 * 10);
    failures++;
    $display("FAIL watchdog: got no completion expected finish within 80000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
